// File: rtl/fetch_unit_if.sv
// Fetch front-end bundle: instruction-memory request/response, redirect and decode handoff.
interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            inst_valid;
   logic            inst_ready;
   logic [XLEN-1:0] inst_data;
   logic [XLEN-1:0] inst_pc;

   modport master (
      output imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready
   );

   modport slave (
      input  imem_req_valid, imem_addr, inst_valid, inst_data, inst_pc,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data,
             redirect_valid, redirect_pc, inst_ready
   );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited pipelined imem requests, in-order PC queue,
// first-word-fall-through prefetch FIFO, and redirect with stale-response dropping.
module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 4,
   parameter int              MAX_OUT  = 2
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1) + 1;
   localparam int PW = $clog2(DEPTH);
   localparam int QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
   localparam logic [QW-1:0] Q_LAST    = QW'(MAX_OUT - 1);

   logic [XLEN-1:0] pc_q;
   logic [CW-1:0]   out_q;
   logic [CW-1:0]   drop_q;
   logic [CW-1:0]   cnt_q;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic [QW-1:0]   pq_rd;
   logic [QW-1:0]   pq_wr;
   logic [XLEN-1:0] fifo_data [DEPTH];
   logic [XLEN-1:0] fifo_pc   [DEPTH];
   logic [XLEN-1:0] pc_queue  [MAX_OUT];

   logic          accept;
   logic          rsp;
   logic          push;
   logic          pop;
   logic [CW-1:0] credit;
   logic [CW-1:0] out_next;
   logic          unused_redirect_bits;

   assign unused_redirect_bits = ^bus.redirect_pc[1:0];

   // Slots already spoken for: live (non-dropped) requests plus buffered entries.
   assign credit             = out_q - drop_q + cnt_q;
   assign bus.imem_req_valid = rst && (out_q < MAX_OUT_C) && (credit < DEPTH_C);
   assign bus.imem_addr      = pc_q;
   assign bus.inst_valid     = (cnt_q != '0);
   assign bus.inst_data      = fifo_data[rd_ptr];
   assign bus.inst_pc        = fifo_pc[rd_ptr];

   assign accept   = bus.imem_req_valid && bus.imem_req_ready;
   assign rsp      = rst && bus.imem_rsp_valid;
   assign push     = rsp && (drop_q == '0) && !bus.redirect_valid;
   assign pop      = bus.inst_valid && bus.inst_ready;
   assign out_next = out_q + CW'(accept) - CW'(rsp);

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q   <= RESET_PC;
         out_q  <= '0;
         drop_q <= '0;
         cnt_q  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         pq_rd  <= '0;
         pq_wr  <= '0;
      end else begin
         out_q <= out_next;
         if (accept) pq_wr <= (pq_wr == Q_LAST) ? '0 : pq_wr + QW'(1);
         if (rsp)    pq_rd <= (pq_rd == Q_LAST) ? '0 : pq_rd + QW'(1);
         // Redirect flushes the buffer and marks every request still in flight as stale.
         if (bus.redirect_valid) begin
            pc_q   <= {bus.redirect_pc[XLEN-1:2], 2'b00};
            drop_q <= out_next;
            cnt_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (accept) pc_q <= pc_q + XLEN'(4);
            if (rsp && (drop_q != '0)) drop_q <= drop_q - CW'(1);
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) pc_queue[pq_wr] <= pc_q;
      if (push) begin
         fifo_data[wr_ptr] <= bus.imem_rsp_data;
         fifo_pc[wr_ptr]   <= pc_queue[pq_rd];
      end
   end

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst) begin
         assert (out_q <= MAX_OUT_C);
         assert (cnt_q <= DEPTH_C);
         assert (!(bus.imem_rsp_valid && (out_q == '0)));
         assert (RESET_PC[1:0] == 2'b00);
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (DEPTH 4 at PC 0, DEPTH 8 at PC FFFFFFF8)
// sharing control inputs, each with its own in-order memory model.
module tb_fetch_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int b_rsp_cnt = 0;

   logic        req_ready, inst_ready, redir_v, rsp_hold, rsp_rand;
   logic [31:0] redir_pc;
   logic        a_rsp_v, b_rsp_v;
   logic [31:0] a_rsp_d, b_rsp_d;

   logic [31:0] a_mem[$], b_mem[$];
   logic [31:0] a_got_pc[$], a_got_data[$], b_got_pc[$], b_got_data[$];
   logic [31:0] a_issued[$];
   int          a_got_cyc[$];

   fetch_unit_if #(.XLEN(32)) bus_a ();
   fetch_unit_if #(.XLEN(32)) bus_b ();

   assign bus_a.imem_req_ready = req_ready;
   assign bus_a.imem_rsp_valid = a_rsp_v;
   assign bus_a.imem_rsp_data  = a_rsp_d;
   assign bus_a.redirect_valid = redir_v;
   assign bus_a.redirect_pc    = redir_pc;
   assign bus_a.inst_ready     = inst_ready;
   assign bus_b.imem_req_ready = req_ready;
   assign bus_b.imem_rsp_valid = b_rsp_v;
   assign bus_b.imem_rsp_data  = b_rsp_d;
   assign bus_b.redirect_valid = redir_v;
   assign bus_b.redirect_pc    = redir_pc;
   assign bus_b.inst_ready     = inst_ready;

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .DEPTH(4), .MAX_OUT(2)) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.master)
   );
   fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(8), .MAX_OUT(2)) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b.master)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (addr * 32'd7) ^ 32'hC0DE_0000;
   endfunction

   // One clock: drive responses, record pops and accepts, advance the memory models.
   task automatic cycle();
      logic        a_acc, b_acc, a_rsp, b_rsp;
      logic [31:0] a_addr, b_addr;
      a_rsp_v = 1'b0; a_rsp_d = '0;
      b_rsp_v = 1'b0; b_rsp_d = '0;
      if (rst && !rsp_hold && a_mem.size() > 0 && (!rsp_rand || $urandom_range(0, 2) != 0)) begin
         a_rsp_v = 1'b1; a_rsp_d = mem_word(a_mem[0]);
      end
      if (rst && !rsp_hold && b_mem.size() > 0 && (!rsp_rand || $urandom_range(0, 2) != 0)) begin
         b_rsp_v = 1'b1; b_rsp_d = mem_word(b_mem[0]);
      end
      #1;
      a_acc = bus_a.imem_req_valid && req_ready; a_addr = bus_a.imem_addr; a_rsp = a_rsp_v;
      b_acc = bus_b.imem_req_valid && req_ready; b_addr = bus_b.imem_addr; b_rsp = b_rsp_v;
      if (bus_a.inst_valid && inst_ready) begin
         a_got_pc.push_back(bus_a.inst_pc); a_got_data.push_back(bus_a.inst_data); a_got_cyc.push_back(cyc);
      end
      if (bus_b.inst_valid && inst_ready) begin
         b_got_pc.push_back(bus_b.inst_pc); b_got_data.push_back(bus_b.inst_data);
      end
      if (a_acc) a_issued.push_back(a_addr);
      @(posedge clk);
      cyc++;
      if (!rst) begin
         a_mem.delete(); b_mem.delete();
      end else begin
         if (a_rsp) void'(a_mem.pop_front());
         if (a_acc) a_mem.push_back(a_addr);
         if (b_rsp) begin void'(b_mem.pop_front()); b_rsp_cnt++; end
         if (b_acc) b_mem.push_back(b_addr);
      end
      @(negedge clk);
   endtask

   // Leaves rst low at a negedge with all bench records cleared.
   task automatic reset_dut();
      rst = 1'b0; redir_v = 1'b0; redir_pc = '0; rsp_hold = 1'b0; rsp_rand = 1'b0;
      req_ready = 1'b1; inst_ready = 1'b0;
      repeat (2) cycle();
      a_got_pc.delete(); a_got_data.delete(); a_got_cyc.delete(); a_issued.delete();
      b_got_pc.delete(); b_got_data.delete(); b_rsp_cnt = 0;
   endtask

   task automatic test_reset();
      $display("[TB] test_reset");
      reset_dut();
      checks++; if (bus_a.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid: got %b expected 0", bus_a.imem_req_valid); end
      checks++; if (bus_a.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %b expected 0", bus_a.inst_valid); end
      checks++; if (bus_a.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_addr_a: got %h expected 00000000", bus_a.imem_addr); end
      checks++; if (bus_b.imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL reset_addr_b: got %h expected fffffff8", bus_b.imem_addr); end
      checks++; if (bus_b.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_req_valid_b: got %b expected 0", bus_b.imem_req_valid); end
      rst = 1'b1;
      #1;
      checks++; if (bus_a.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_inst_valid: got %b expected 0", bus_a.inst_valid); end
      checks++; if (bus_a.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL post_reset_addr: got %h expected 00000000", bus_a.imem_addr); end
      @(negedge clk);
   endtask

   task automatic test_steady();
      int start;
      $display("[TB] test_steady");
      reset_dut(); inst_ready = 1'b1; rst = 1'b1; start = cyc;
      repeat (16) cycle();
      checks++;
      if (a_got_pc.size() < 8) begin
         errors++; $display("[TB] FAIL steady_count: got %0d pops expected at least 8", a_got_pc.size());
      end else begin
         checks++; if (a_got_cyc[0] !== start + 2) begin errors++; $display("[TB] FAIL steady_latency: got cycle %0d expected %0d", a_got_cyc[0], start + 2); end
         for (int i = 0; i < 8; i++) begin
            checks++; if (a_issued[i] !== 32'(4 * i)) begin errors++; $display("[TB] FAIL steady_addr[%0d]: got %h expected %h", i, a_issued[i], 32'(4 * i)); end
            checks++; if (a_got_pc[i] !== 32'(4 * i)) begin errors++; $display("[TB] FAIL steady_pc[%0d]: got %h expected %h", i, a_got_pc[i], 32'(4 * i)); end
            checks++; if (a_got_data[i] !== mem_word(32'(4 * i))) begin errors++; $display("[TB] FAIL steady_data[%0d]: got %h expected %h", i, a_got_data[i], mem_word(32'(4 * i))); end
            if (i > 0) begin
               checks++; if (a_got_cyc[i] !== a_got_cyc[i-1] + 1) begin errors++; $display("[TB] FAIL steady_back_to_back[%0d]: got cycle %0d expected %0d", i, a_got_cyc[i], a_got_cyc[i-1] + 1); end
            end
         end
      end
   endtask

   task automatic test_stall();
      $display("[TB] test_stall");
      reset_dut(); inst_ready = 1'b0; rst = 1'b1;
      repeat (20) cycle();
      checks++; if (bus_a.inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_inst_valid: got %b expected 1", bus_a.inst_valid); end
      checks++; if (bus_a.imem_req_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_valid: got %b expected 0", bus_a.imem_req_valid); end
      checks++; if (a_issued.size() !== 4) begin errors++; $display("[TB] FAIL stall_issued: got %0d expected 4", a_issued.size()); end
      checks++; if (bus_a.inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL stall_head_pc: got %h expected 00000000", bus_a.inst_pc); end
      checks++; if (bus_a.inst_data !== mem_word(32'h0)) begin errors++; $display("[TB] FAIL stall_head_data: got %h expected %h", bus_a.inst_data, mem_word(32'h0)); end
      inst_ready = 1'b1;
      repeat (10) cycle();
      checks++;
      if (a_got_pc.size() < 5) begin
         errors++; $display("[TB] FAIL stall_release_count: got %0d pops expected at least 5", a_got_pc.size());
      end else begin
         for (int i = 0; i < a_got_pc.size(); i++) begin
            checks++; if (a_got_pc[i] !== 32'(4 * i)) begin errors++; $display("[TB] FAIL stall_release_pc[%0d]: got %h expected %h", i, a_got_pc[i], 32'(4 * i)); end
            checks++; if (a_got_data[i] !== mem_word(32'(4 * i))) begin errors++; $display("[TB] FAIL stall_release_data[%0d]: got %h expected %h", i, a_got_data[i], mem_word(32'(4 * i))); end
         end
      end
   endtask

   task automatic test_redirect_flush();
      int n;
      $display("[TB] test_redirect_flush");
      reset_dut(); inst_ready = 1'b0; rst = 1'b1;
      n = 0;
      while (b_rsp_cnt < 3 && n < 20) begin cycle(); n++; end
      rsp_hold = 1'b1;
      n = 0;
      while (b_mem.size() < 2 && n < 20) begin cycle(); n++; end
      checks++; if (b_mem.size() !== 2 || b_rsp_cnt !== 3) begin errors++; $display("[TB] FAIL flush_setup: got %0d in flight %0d buffered expected 2 and 3", b_mem.size(), b_rsp_cnt); end
      checks++; if (bus_b.inst_pc !== 32'hFFFF_FFF8) begin errors++; $display("[TB] FAIL flush_head_before: got %h expected fffffff8", bus_b.inst_pc); end
      redir_v = 1'b1; redir_pc = 32'h0000_0100;
      cycle();
      redir_v = 1'b0;
      checks++; if (bus_b.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_inst_valid: got %b expected 0", bus_b.inst_valid); end
      checks++; if (bus_b.imem_addr !== 32'h0000_0100) begin errors++; $display("[TB] FAIL flush_addr: got %h expected 00000100", bus_b.imem_addr); end
      rsp_hold = 1'b0; inst_ready = 1'b1;
      repeat (12) cycle();
      checks++;
      if (b_got_pc.size() < 2) begin
         errors++; $display("[TB] FAIL flush_count: got %0d pops expected at least 2", b_got_pc.size());
      end else begin
         for (int i = 0; i < b_got_pc.size(); i++) begin
            checks++; if (b_got_pc[i] !== 32'h100 + 32'(4 * i)) begin errors++; $display("[TB] FAIL flush_pc[%0d]: got %h expected %h", i, b_got_pc[i], 32'h100 + 32'(4 * i)); end
            checks++; if (b_got_data[i] !== mem_word(32'h100 + 32'(4 * i))) begin errors++; $display("[TB] FAIL flush_data[%0d]: got %h expected %h", i, b_got_data[i], mem_word(32'h100 + 32'(4 * i))); end
         end
      end
   endtask

   task automatic test_redirect_collide();
      int n;
      int base;
      $display("[TB] test_redirect_collide");
      reset_dut(); inst_ready = 1'b1; rst = 1'b1;
      repeat (4) cycle();
      n = 0;
      while (!(bus_a.imem_req_valid && a_mem.size() > 0) && n < 10) begin cycle(); n++; end
      checks++; if (!(bus_a.imem_req_valid && a_mem.size() > 0)) begin errors++; $display("[TB] FAIL collide_setup: got req_valid %b in flight %0d expected 1 and >0", bus_a.imem_req_valid, a_mem.size()); end
      redir_v = 1'b1; redir_pc = 32'h0000_0203;
      cycle();
      redir_v = 1'b0;
      base = a_got_pc.size();
      checks++; if (bus_a.imem_addr !== 32'h0000_0200) begin errors++; $display("[TB] FAIL collide_addr: got %h expected 00000200", bus_a.imem_addr); end
      checks++; if (bus_a.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL collide_inst_valid: got %b expected 0", bus_a.inst_valid); end
      repeat (10) cycle();
      checks++;
      if (a_got_pc.size() < base + 2) begin
         errors++; $display("[TB] FAIL collide_count: got %0d pops expected at least 2", a_got_pc.size() - base);
      end else begin
         for (int i = base; i < a_got_pc.size(); i++) begin
            checks++; if (a_got_pc[i] !== 32'h200 + 32'(4 * (i - base))) begin errors++; $display("[TB] FAIL collide_pc[%0d]: got %h expected %h", i - base, a_got_pc[i], 32'h200 + 32'(4 * (i - base))); end
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_pc [4];
      exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      $display("[TB] test_wrap");
      reset_dut(); inst_ready = 1'b1; rst = 1'b1;
      repeat (10) cycle();
      checks++;
      if (b_got_pc.size() < 4) begin
         errors++; $display("[TB] FAIL wrap_count: got %0d pops expected at least 4", b_got_pc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            checks++; if (b_got_pc[i] !== exp_pc[i]) begin errors++; $display("[TB] FAIL wrap_pc[%0d]: got %h expected %h", i, b_got_pc[i], exp_pc[i]); end
            checks++; if (b_got_data[i] !== mem_word(exp_pc[i])) begin errors++; $display("[TB] FAIL wrap_data[%0d]: got %h expected %h", i, b_got_data[i], mem_word(exp_pc[i])); end
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc;
      int          pops;
      $display("[TB] test_random");
      reset_dut(); rst = 1'b1; rsp_rand = 1'b1;
      exp_pc = 32'h0; pops = 0;
      for (int t = 0; t < 4000; t++) begin
         req_ready  = ($urandom_range(0, 3) != 0);
         inst_ready = ($urandom_range(0, 3) != 0);
         redir_v    = ($urandom_range(0, 39) == 0);
         redir_pc   = 32'($urandom_range(0, 32'h0000_FFFF));
         if (bus_a.inst_valid && inst_ready) begin
            pops++;
            checks++; if (bus_a.inst_pc !== exp_pc) begin errors++; $display("[TB] FAIL random_pc at cycle %0d: got %h expected %h", cyc, bus_a.inst_pc, exp_pc); end
            checks++; if (bus_a.inst_data !== mem_word(exp_pc)) begin errors++; $display("[TB] FAIL random_data at cycle %0d: got %h expected %h", cyc, bus_a.inst_data, mem_word(exp_pc)); end
            exp_pc = exp_pc + 32'd4;
         end
         if (redir_v) exp_pc = {redir_pc[31:2], 2'b00};
         cycle();
      end
      redir_v = 1'b0;
      checks++; if (pops < 500) begin errors++; $display("[TB] FAIL random_progress: got %0d pops expected at least 500", pops); end
   endtask

   initial begin
      rst = 1'b0; req_ready = 1'b0; inst_ready = 1'b0; redir_v = 1'b0; redir_pc = '0;
      rsp_hold = 1'b0; rsp_rand = 1'b0;
      a_rsp_v = 1'b0; a_rsp_d = '0; b_rsp_v = 1'b0; b_rsp_d = '0;
      @(negedge clk);
      test_reset();
      test_steady();
      test_stall();
      test_redirect_flush();
      test_redirect_collide();
      test_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
